// File: rtl/acum_sequencer_pkg.sv
// Shared types for the MAC sequencer: select codes, FSM states, limits.
// Ports: none (package).
package acum_sequencer_pkg;

  localparam int DEF_W       = 25;
  localparam int DEF_N_TERMS = 8;
  localparam int DEF_IDX_W   = 5;

  localparam logic [1:0] SEL_UK   = 2'b00;
  localparam logic [1:0] SEL_ACUM = 2'b01;
  localparam logic [1:0] SEL_ZERO = 2'b10;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    REQ,
    WAIT,
    OUT
  } state_t;

  // Saturation limits for a w-bit two's complement value,
  // returned in 64 bits; callers truncate to w.
  function automatic logic [63:0] sat_hi(int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_lo(int w);
    return ~sat_hi(w);
  endfunction

endpackage

// File: rtl/acum_sequencer_if.sv
// Sample-in, term-fetch and Yk-out signal bundle of the MAC sequencer.
// Modports: slave = sequencer side, master = datapath/environment side.
interface acum_sequencer_if
  import acum_sequencer_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int IDX_W = DEF_IDX_W
) ();

  logic                    uk_valid;
  logic                    uk_ready;
  logic signed [W-1:0]     uk;
  logic        [IDX_W-1:0] term_idx;
  logic                    term_req;
  logic                    term_valid;
  logic signed [W-1:0]     term_data;
  logic        [1:0]       acc_sel;
  logic signed [W-1:0]     yk;
  logic                    yk_valid;
  logic                    sat_flag;

  modport slave (
    input  uk_valid,
    input  uk,
    input  term_valid,
    input  term_data,
    output uk_ready,
    output term_idx,
    output term_req,
    output acc_sel,
    output yk,
    output yk_valid,
    output sat_flag
  );

  modport master (
    output uk_valid,
    output uk,
    output term_valid,
    output term_data,
    input  uk_ready,
    input  term_idx,
    input  term_req,
    input  acc_sel,
    input  yk,
    input  yk_valid,
    input  sat_flag
  );

endinterface

// File: rtl/acum_sequencer_sat_add.sv
// W-bit signed adder clamping to the representable range.
// Ports: a, b operands; sum clamped result; ovf high when clamped.
module acum_sequencer_sat_add
  import acum_sequencer_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  localparam logic signed [W-1:0] MAXV = W'(sat_hi(W));
  localparam logic signed [W-1:0] MINV = W'(sat_lo(W));

  logic [W:0] wide;

  assign wide = {a[W-1], a} + {b[W-1], b};

  // Top two bits disagree only when the true sum left the W-bit range;
  // the extra sign bit tells which rail to clamp to.
  assign ovf = wide[W] ^ wide[W-1];

  always_comb begin
    sum = wide[W-1:0];
    if (ovf) begin
      sum = wide[W] ? MINV : MAXV;
    end
  end

endmodule

// File: rtl/acum_sequencer.sv
// Per-sample MAC controller: seed with Uk, add N_TERMS saturated terms, emit Yk.
// Ports: clk, reset_n (sync, active-low), bus (acum_sequencer_if.slave).
module acum_sequencer
  import acum_sequencer_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int N_TERMS = DEF_N_TERMS,
  parameter int IDX_W   = DEF_IDX_W
) (
  input logic              clk,
  input logic              reset_n,
  acum_sequencer_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_TERMS - 1);

  state_t                  state;
  state_t                  state_nx;
  logic signed [W-1:0]     acc;
  logic signed [W-1:0]     acc_nx;
  logic signed [W-1:0]     sum;
  logic signed [W-1:0]     yk_q;
  logic        [IDX_W-1:0] idx;
  logic        [IDX_W-1:0] idx_nx;
  logic                    sat_q;
  logic                    sat_nx;
  logic                    ykv_q;
  logic                    ovf;

  acum_sequencer_sat_add #(
    .W (W)
  ) u_add (
    .a   (acc),
    .b   (bus.term_data),
    .sum (sum),
    .ovf (ovf)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= CLEAR;
      acc   <= '0;
      idx   <= '0;
      sat_q <= 1'b0;
      yk_q  <= '0;
      ykv_q <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      idx   <= idx_nx;
      sat_q <= sat_nx;
      // OUT lasts one cycle, so this pulse can never repeat back to back.
      ykv_q <= (state == OUT);
      if (state == OUT) begin
        yk_q <= acc;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    acc_nx       = acc;
    idx_nx       = idx;
    sat_nx       = sat_q;
    bus.uk_ready = 1'b0;
    bus.term_req = 1'b0;
    bus.acc_sel  = SEL_ZERO;
    unique case (state)
      CLEAR: begin
        acc_nx   = '0;
        state_nx = IDLE;
      end
      IDLE: begin
        bus.uk_ready = 1'b1;
        if (bus.uk_valid) begin
          bus.acc_sel = SEL_UK;
          acc_nx      = bus.uk;
          sat_nx      = 1'b0;
          idx_nx      = '0;
          state_nx    = REQ;
        end
      end
      REQ: begin
        bus.term_req = 1'b1;
        bus.acc_sel  = SEL_ACUM;
        state_nx     = WAIT;
      end
      WAIT: begin
        bus.acc_sel = SEL_ACUM;
        if (bus.term_valid) begin
          acc_nx = sum;
          if (ovf) begin
            sat_nx = 1'b1;
          end
          if (idx == LAST) begin
            state_nx = OUT;
          end else begin
            idx_nx   = idx + 1'b1;
            state_nx = REQ;
          end
        end
      end
      OUT: begin
        acc_nx   = '0;
        idx_nx   = '0;
        state_nx = IDLE;
      end
      default: begin
        state_nx = CLEAR;
      end
    endcase
  end

  assign bus.term_idx = idx;
  assign bus.yk       = yk_q;
  assign bus.yk_valid = ykv_q;
  assign bus.sat_flag = sat_q;

endmodule

// File: tb/tb_acum_sequencer.sv
// Randomized self-checking bench for acum_sequencer with a sum/clamp model.
// Ports: none (top-level testbench).
module tb_acum_sequencer;

  localparam int W     = 25;
  localparam int N     = 8;
  localparam int IDX_W = 5;
  localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (W - 1));

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   tests_run = 0;
  int   failed = 0;
  int   resp_dly = 1;
  int   stray_n = 0;
  int   yk_cnt = 0;
  int   adj_cnt = 0;
  int   ykv_at[$];
  longint ykv_val[$];
  int   idx_log[$];
  logic signed [W-1:0] terms [N];

  acum_sequencer_if #(.W(W), .IDX_W(IDX_W)) sif ();

  acum_sequencer #(
    .W       (W),
    .N_TERMS (N),
    .IDX_W   (IDX_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (sif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: yk pulses, adjacency, requested term indices.
  initial begin : mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (sif.yk_valid === 1'b1) begin
        yk_cnt++;
        ykv_at.push_back(cyc);
        ykv_val.push_back(longint'(sif.yk));
        if (prev) adj_cnt++;
      end
      prev = (sif.yk_valid === 1'b1);
      if (sif.term_req === 1'b1) idx_log.push_back(int'(sif.term_idx));
    end
  end

  // Term responder: answers each request resp_dly cycles later.
  initial begin : resp
    int cnt;
    int pidx;
    cnt = -1;
    pidx = 0;
    sif.term_valid = 1'b0;
    sif.term_data = '0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) cnt = -1;
      else if (sif.term_req === 1'b1) begin
        pidx = int'(sif.term_idx);
        cnt = resp_dly;
      end
      @(posedge clk);
      #1;
      sif.term_valid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          sif.term_valid = 1'b1;
          sif.term_data = terms[pidx % N];
          cnt = -1;
        end
      end else if (stray_n > 0) begin
        sif.term_valid = 1'b1;
        sif.term_data = W'($urandom);
        stray_n--;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic void model(input longint seed, output longint y,
                                output bit s);
    longint a;
    a = seed;
    s = 1'b0;
    for (int i = 0; i < N; i++) begin
      a = a + longint'(terms[i]);
      if (a > MAXV) begin a = MAXV; s = 1'b1; end
      else if (a < MINV) begin a = MINV; s = 1'b1; end
    end
    y = a;
  endfunction

  task automatic send_uk(input longint v, output int at,
                         output logic [1:0] sel, output bit ok);
    ok = 1'b0;
    at = 0;
    sel = 2'b11;
    @(posedge clk);
    #1;
    sif.uk_valid = 1'b1;
    sif.uk = W'(v);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sif.uk_ready === 1'b1) begin
        at = cyc;
        sel = sif.acc_sel;
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    sif.uk_valid = 1'b0;
  endtask

  task automatic wait_yk(input int budget, output bit ok, output longint y,
                         output int at, output int rdy);
    ok = 1'b0;
    y = 0;
    at = 0;
    rdy = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (sif.yk_valid === 1'b1) begin
        ok = 1'b1;
        y = longint'(sif.yk);
        at = cyc;
        break;
      end
      if (sif.uk_ready !== 1'b0) rdy++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({sif.yk_valid, sif.uk_ready, sif.term_req, sif.sat_flag} !== 4'b0) begin
      failed++;
      $display("FAIL reset_flags: got %b want 0000",
               {sif.yk_valid, sif.uk_ready, sif.term_req, sif.sat_flag});
    end
    tests_run++;
    if (sif.yk !== '0 || sif.term_idx !== '0) begin
      failed++;
      $display("FAIL reset_regs: yk %0d idx %0d want 0 0", sif.yk, sif.term_idx);
    end
    tests_run++;
    if (sif.acc_sel !== 2'b10) begin
      failed++;
      $display("FAIL reset_sel: got %b want 10", sif.acc_sel);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (sif.uk_ready !== 1'b0 || sif.acc_sel !== 2'b10) begin
      failed++;
      $display("FAIL clear_cycle: ready %b sel %b want 0 10", sif.uk_ready, sif.acc_sel);
    end
    @(negedge clk);
    tests_run++;
    if (sif.uk_ready !== 1'b1) begin
      failed++;
      $display("FAIL idle_ready: got %b want 1", sif.uk_ready);
    end
  endtask

  task automatic test_basic();
    int at, t, rdy;
    logic [1:0] sel;
    bit ok, s;
    longint y, ey;
    int bad;
    for (int i = 0; i < N; i++) terms[i] = W'(i + 1);
    resp_dly = 1;
    idx_log.delete();
    model(100, ey, s);
    send_uk(100, at, sel, ok);
    tests_run++;
    if (!ok || sel !== 2'b00) begin
      failed++;
      $display("FAIL basic_accept: ok %0d sel %b want 1 00", ok, sel);
    end
    @(negedge clk);
    tests_run++;
    if (sif.acc_sel !== 2'b01 || sif.term_req !== 1'b1) begin
      failed++;
      $display("FAIL basic_req: sel %b req %b want 01 1", sif.acc_sel, sif.term_req);
    end
    wait_yk(100, ok, y, t, rdy);
    tests_run++;
    if (!ok || y !== 136 || y !== ey) begin
      failed++;
      $display("FAIL basic_yk: ok %0d got %0d want 136", ok, y);
    end
    tests_run++;
    if (t - at !== 18) begin
      failed++;
      $display("FAIL basic_latency: got %0d want 18", t - at);
    end
    bad = (idx_log.size() == N) ? 0 : 1;
    for (int i = 0; i < idx_log.size() && i < N; i++) if (idx_log[i] != i) bad++;
    tests_run++;
    if (bad != 0) begin
      failed++;
      $display("FAIL basic_idx_seq: %0d requests, %0d bad, want 0..7", idx_log.size(), bad);
    end
    @(negedge clk);
    tests_run++;
    if (sif.yk_valid !== 1'b0 || sif.yk !== 25'sd136) begin
      failed++;
      $display("FAIL basic_hold: valid %b yk %0d want 0 136", sif.yk_valid, sif.yk);
    end
  endtask

  task automatic test_pos_sat();
    int at, t, rdy;
    logic [1:0] sel;
    bit ok;
    longint y;
    for (int i = 0; i < N; i++) terms[i] = '0;
    terms[0] = W'(10);
    resp_dly = 1;
    send_uk(16777215, at, sel, ok);
    wait_yk(100, ok, y, t, rdy);
    tests_run++;
    if (!ok || y !== MAXV) begin
      failed++;
      $display("FAIL possat_yk: ok %0d got %0d want %0d", ok, y, MAXV);
    end
    tests_run++;
    if (sif.sat_flag !== 1'b1) begin
      failed++;
      $display("FAIL possat_flag: got %b want 1", sif.sat_flag);
    end
    terms[0] = '0;
    send_uk(3, at, sel, ok);
    @(negedge clk);
    tests_run++;
    if (sif.sat_flag !== 1'b0) begin
      failed++;
      $display("FAIL possat_clear: got %b want 0", sif.sat_flag);
    end
    wait_yk(100, ok, y, t, rdy);
    tests_run++;
    if (!ok || y !== 3) begin
      failed++;
      $display("FAIL possat_next: ok %0d got %0d want 3", ok, y);
    end
  endtask

  task automatic test_neg_stall();
    int at, t, rdy, n0, l0, nr;
    logic [1:0] sel;
    bit ok;
    longint y;
    for (int i = 0; i < N; i++) terms[i] = -W'(3);
    resp_dly = 4;
    send_uk(-50, at, sel, ok);
    wait_yk(300, ok, y, t, rdy);
    tests_run++;
    if (!ok || y !== -74) begin
      failed++;
      $display("FAIL neg_yk: ok %0d got %0d want -74", ok, y);
    end
    tests_run++;
    if (rdy != 0) begin
      failed++;
      $display("FAIL neg_busy_ready: got %0d ready cycles want 0", rdy);
    end
    tests_run++;
    if (t - at !== 42) begin
      failed++;
      $display("FAIL neg_latency: got %0d want 42", t - at);
    end
    resp_dly = 1;
    n0 = yk_cnt;
    l0 = idx_log.size();
    nr = 0;
    stray_n = 3;
    repeat (6) begin
      @(negedge clk);
      if (sif.uk_ready !== 1'b1) nr++;
    end
    tests_run++;
    if (yk_cnt != n0 || idx_log.size() != l0 || nr != 0) begin
      failed++;
      $display("FAIL stray_idle: pulses %0d reqs %0d notready %0d want 0 0 0",
               yk_cnt - n0, idx_log.size() - l0, nr);
    end
    tests_run++;
    if (sif.yk !== -25'sd74) begin
      failed++;
      $display("FAIL stray_hold: got %0d want -74", sif.yk);
    end
  endtask

  task automatic test_random();
    int at, t, rdy;
    logic [1:0] sel;
    bit ok, s;
    longint y, ey, seed;
    logic signed [W-1:0] tmp;
    for (int n = 0; n < 8; n++) begin
      if (n == 0) begin
        seed = MINV + 5;
        for (int i = 0; i < N; i++) terms[i] = -W'(7);
      end else begin
        tmp = W'($urandom);
        seed = longint'(tmp);
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 1) == 1) terms[i] = W'($urandom);
          else terms[i] = W'(int'($urandom_range(0, 2000)) - 1000);
        end
      end
      resp_dly = $urandom_range(1, 3);
      model(seed, ey, s);
      send_uk(seed, at, sel, ok);
      wait_yk(300, ok, y, t, rdy);
      tests_run++;
      if (!ok || y !== ey || sif.sat_flag !== s) begin
        failed++;
        $display("FAIL rand_%0d: ok %0d yk %0d sat %b want %0d %b",
                 n, ok, y, sif.sat_flag, ey, s);
      end
    end
    resp_dly = 1;
  endtask

  task automatic test_mid_reset();
    int at, t, rdy, n0;
    logic [1:0] sel;
    bit ok, found;
    longint y;
    for (int i = 0; i < N; i++) terms[i] = '0;
    resp_dly = 6;
    send_uk(77, at, sel, ok);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sif.term_req === 1'b1 && sif.term_idx === 5'd3) begin
        found = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!found) begin
      failed++;
      $display("FAIL midrst_reach: got no request at idx 3, want one");
    end
    @(posedge clk);
    #1;
    n0 = yk_cnt;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    resp_dly = 1;
    repeat (25) @(negedge clk);
    tests_run++;
    if (yk_cnt != n0 || sif.yk !== '0) begin
      failed++;
      $display("FAIL midrst_abort: pulses %0d yk %0d want 0 0", yk_cnt - n0, sif.yk);
    end
    send_uk(5, at, sel, ok);
    wait_yk(100, ok, y, t, rdy);
    tests_run++;
    if (!ok || y !== 5) begin
      failed++;
      $display("FAIL midrst_next: ok %0d got %0d want 5", ok, y);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    bit ok1, ok2;
    for (int i = 0; i < N; i++) terms[i] = '0;
    resp_dly = 1;
    n0 = ykv_at.size();
    adj_cnt = 0;
    ok1 = 1'b0;
    ok2 = 1'b0;
    @(posedge clk);
    #1;
    sif.uk_valid = 1'b1;
    sif.uk = W'(1);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sif.uk_ready === 1'b1) begin ok1 = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    sif.uk = W'(2);
    @(negedge clk);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sif.uk_ready === 1'b1) begin ok2 = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    sif.uk_valid = 1'b0;
    for (int k = 0; k < 100 && ykv_at.size() < n0 + 2; k++) @(negedge clk);
    tests_run++;
    if (!ok1 || !ok2 || ykv_at.size() != n0 + 2) begin
      failed++;
      $display("FAIL b2b_count: acc %0d%0d pulses %0d want 11 2",
               ok1, ok2, ykv_at.size() - n0);
    end else begin
      tests_run++;
      if (ykv_val[n0] !== 1 || ykv_val[n0+1] !== 2) begin
        failed++;
        $display("FAIL b2b_vals: got %0d %0d want 1 2", ykv_val[n0], ykv_val[n0+1]);
      end
      tests_run++;
      if (ykv_at[n0+1] - ykv_at[n0] < 18) begin
        failed++;
        $display("FAIL b2b_gap: got %0d want >= 18", ykv_at[n0+1] - ykv_at[n0]);
      end
    end
    tests_run++;
    if (adj_cnt != 0) begin
      failed++;
      $display("FAIL b2b_adjacent: got %0d adjacent pulses want 0", adj_cnt);
    end
  endtask

  initial begin
    sif.uk_valid = 1'b0;
    sif.uk = '0;
    for (int i = 0; i < N; i++) terms[i] = '0;
    test_reset();
    test_basic();
    test_pos_sat();
    test_neg_stall();
    test_random();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
